myriscv_mem_responder: RTL and testbench
========================================

# myriscv_mem_responder

Memory responder for the myRiscv single-cycle core. It sits on the far side of the core's `pc`/`instr` fetch port and its `addr`/`wr_en`/`wr_data`/`rd_data` data port. It holds a unified word-addressed memory, services fetches and loads combinationally, and commits byte-lane stores on the clock edge. It also runs a post-reset clear sweep, flags illegal accesses, and counts committed stores for bench and formal observation.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: memory depth in 32-bit words; power of two, 16 to 65536.
- `FILL_WORD`, 32'h0000_0013: value written to every word by the clear sweep (RV32I NOP).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  fetch byte address from core.
- `instr`  out  32  fetched word.
- `addr`  in  32  load/store byte address from core.
- `wr_en`  in  4  store byte-lane enables; bit i writes `wr_data[8i+7:8i]`.
- `wr_data`  in  32  store data, already lane-aligned by core.
- `rd_data`  out  32  load word.
- `ready`  out  1  memory initialised and accepting accesses.
- `fault`  out  1  sticky illegal-access flag.
- `wr_count`  out  16  committed-store count, saturating.

## Operation
- Index: word index `w = byte_addr[AW+1:2]`, where `AW = log2(DEPTH_WORDS)`. An address is in range iff `byte_addr[31:AW+2] == 0`.
- FSM states:
  - CLEAR: reset state. An index counter `clr_idx` starts at 0 and writes `FILL_WORD` to `mem[clr_idx]` each edge. After writing index `DEPTH_WORDS-1`, the FSM goes to RUN. Core stores are ignored in CLEAR.
  - RUN: normal service. No exit except reset.
- Reads are combinational in both states:
  - In RUN: `instr = mem[pc index]` and `rd_data = mem[addr index]`. Either one reads 32'h0 when its address is out of range.
  - In CLEAR: `instr = FILL_WORD` and `rd_data = 0`.
  - A read of a word being written in the same cycle returns the old contents.
- Stores in RUN: committed on the rising edge when `wr_en != 0`, `addr` is in range, and the access is legal. Only the enabled lanes change.
- Legal store: `addr[1:0] == 0` when `wr_en == 4'b1111`; `addr[0] == 0` when `wr_en` is `4'b0011` or `4'b1100`; any single-lane `wr_en` is legal. Any other non-zero `wr_en` pattern is illegal.
- Fault conditions, sampled in RUN only: `pc[1:0] != 0`, `pc` out of range, an illegal store, or a store with `addr` out of range. Any of these sets `fault` on the edge; it stays set until reset. A faulting store does not modify memory and does not increment `wr_count`.
- `wr_count`: increments by 1 on each committed store and holds at 16'hFFFF.

## Timing
- Reset asserted, asynchronously: FSM=CLEAR, `clr_idx`=0, `ready`=0, `fault`=0, `wr_count`=0. `instr`=`FILL_WORD` and `rd_data`=0 combinationally. Memory contents are unchanged.
- Clear sweep: after reset release, edge k (k=1..DEPTH_WORDS) writes word k-1. `ready` rises on edge DEPTH_WORDS, so the first RUN cycle follows it.
- Reset mid-sweep: aborts the sweep. After release the sweep restarts from index 0 and takes the full DEPTH_WORDS edges again.
- Store latency: the write is visible on `rd_data`/`instr` in the cycle after its commit edge.
- A store and a fault on the same edge: the store is suppressed and `fault` is set.
- `wr_count` at 16'hFFFF plus a committed store: the store commits and the count stays at 16'hFFFF.

## Configuration
- `MYRISCV_MEM_CLEAR_EN` defined: CLEAR state and sweep exist as described.
- Not defined:
  - No CLEAR sweep. The FSM still resets to CLEAR but leaves it on the first rising edge after reset release, so `ready` rises on that edge.
  - Memory contents are never initialised by the block (X in simulation, unconstrained in formal).
  - Core stores on that first edge are ignored, as in CLEAR.

## Test plan
- Macro on, `DEPTH_WORDS`=16. Release reset, then read every word -> `ready` rises exactly on edge 16, and all 16 words read 32'h0000_0013.
- RUN, store word: `addr`=0x8, `wr_en`=4'b1111, `wr_data`=0xDEADBEEF, followed by a byte store `addr`=0x9, `wr_en`=4'b0010, `wr_data`=0x0000_5500 -> `rd_data` at 0x8 reads 0xDEAD55EF, and `wr_count`=2.
- Misaligned halfword: `addr`=0x3, `wr_en`=4'b1100 -> `fault`=1 on the next edge, word 0 unchanged, `wr_count` unchanged. `fault` stays 1 through 10 further clean cycles.
- Out-of-range fetch: `pc`=0x40 with `DEPTH_WORDS`=16 -> `instr`=0 the same cycle, and `fault`=1 after the edge.
- Assert reset at sweep edge 7, release 3 cycles later -> `ready`=0, `fault`=0, `wr_count`=0 immediately, and `ready` rises 16 edges after release.
- Preload `wr_count` to 16'hFFFE via 0xFFFE stores, then make 3 legal stores -> `wr_count` reads 16'hFFFF and all 3 stores are visible in memory.

Source files
------------

// File: rtl/myriscv_mem_responder_if.sv
// myriscv_mem_responder_if
//   Bundles the myRiscv core's fetch and data ports towards the memory responder.
//   master : core side   - drives pc, addr, wr_en, wr_data; observes the rest
//   slave  : memory side - drives instr, rd_data, ready, fault, wr_count
//   Signals:
//     pc       [31:0] fetch byte address        instr    [31:0] fetched word
//     addr     [31:0] load/store byte address   rd_data  [31:0] load word
//     wr_en    [3:0]  store byte-lane enables   wr_data  [31:0] lane-aligned store data
//     ready           memory initialised        fault           sticky illegal-access flag
//     wr_count [15:0] saturating committed-store count
interface myriscv_mem_responder_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] addr;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic        fault;
  logic [15:0] wr_count;

  modport master (
    output pc, addr, wr_en, wr_data,
    input  instr, rd_data, ready, fault, wr_count
  );

  modport slave (
    input  pc, addr, wr_en, wr_data,
    output instr, rd_data, ready, fault, wr_count
  );
endinterface

// File: rtl/myriscv_mem_responder.sv
// myriscv_mem_responder
//   Unified word-addressed memory for the myRiscv single-cycle core. Fetches and
//   loads are combinational, byte-lane stores commit on the rising clock edge.
//   Illegal accesses set a sticky fault; committed stores are counted (saturating).
//   Ports:
//     clk      sole clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      myriscv_mem_responder_if.slave (pc/instr fetch, addr/wr_en/wr_data/
//              rd_data data port, ready, fault, wr_count)
//   Parameters:
//     DEPTH_WORDS  memory depth in 32-bit words, power of two, 16..65536
//     FILL_WORD    value written to every word by the post-reset clear sweep
//   Build option:
//     MYRISCV_MEM_CLEAR_EN  when defined, a post-reset sweep writes FILL_WORD to
//                           every word before ready rises; otherwise ready rises on
//                           the first edge after reset release and memory is left
//                           uninitialised.
module myriscv_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] FILL_WORD   = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset_n,
  myriscv_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic          fault_q, fault_d;
  logic [15:0]   wr_count_q, wr_count_d;
`ifdef MYRISCV_MEM_CLEAR_EN
  logic [AW-1:0] clr_idx_q, clr_idx_d;
`endif

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] pc_idx;
  logic [AW-1:0] addr_idx;
  logic          pc_in_range;
  logic          addr_in_range;
  logic          store_req;
  logic          store_legal;
  logic          fault_now;

  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  assign pc_idx        = bus.pc[AW+1:2];
  assign addr_idx      = bus.addr[AW+1:2];
  assign pc_in_range   = (bus.pc[31:AW+2] == '0);
  assign addr_in_range = (bus.addr[31:AW+2] == '0);
  assign store_req     = (bus.wr_en != 4'b0000);

  // Single lanes are always legal; halfwords need an even address, words need
  // a word-aligned address; any other lane pattern is illegal.
  always_comb begin
    store_legal = 1'b0;
    case (bus.wr_en)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: store_legal = 1'b1;
      4'b0011, 4'b1100:                   store_legal = (bus.addr[0] == 1'b0);
      4'b1111:                            store_legal = (bus.addr[1:0] == 2'b00);
      default:                            store_legal = 1'b0;
    endcase
  end

  assign fault_now = (bus.pc[1:0] != 2'b00) || !pc_in_range ||
                     (store_req && (!store_legal || !addr_in_range));

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    wr_count_d  = wr_count_q;
`ifdef MYRISCV_MEM_CLEAR_EN
    clr_idx_d   = clr_idx_q;
`endif
    mem_wstrb   = 4'b0000;
    mem_widx    = addr_idx;
    mem_wdata   = bus.wr_data;
    bus.instr   = FILL_WORD;
    bus.rd_data = '0;

    case (state_q)
      ST_CLEAR: begin
`ifdef MYRISCV_MEM_CLEAR_EN
        mem_wstrb = 4'b1111;
        mem_widx  = clr_idx_q;
        mem_wdata = FILL_WORD;
        clr_idx_d = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
        // DEPTH_WORDS is a power of two, so the last index is all ones.
        if (clr_idx_q == '1) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end

      ST_RUN: begin
        bus.instr   = pc_in_range   ? mem[pc_idx]   : '0;
        bus.rd_data = addr_in_range ? mem[addr_idx] : '0;
        // Any fault on this edge suppresses a store presented alongside it.
        if (fault_now) begin
          fault_d = 1'b1;
        end else if (store_req) begin
          mem_wstrb = bus.wr_en;
          if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      fault_q    <= 1'b0;
      wr_count_q <= '0;
`ifdef MYRISCV_MEM_CLEAR_EN
      clr_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      wr_count_q <= wr_count_d;
`ifdef MYRISCV_MEM_CLEAR_EN
      clr_idx_q  <= clr_idx_d;
`endif
    end
  end

  // Storage has no reset: contents survive reset; writes are blocked while
  // reset is held so an aborted sweep leaves memory alone.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) begin
          mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.ready    = (state_q == ST_RUN);
  assign bus.fault    = fault_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_myriscv_mem_responder.sv
// tb_myriscv_mem_responder
//   Directed bench for myriscv_mem_responder with DEPTH_WORDS=16. A behavioural
//   memory model tracks what every output must be; a compare process checks the
//   DUT against it on every falling clock edge, and directed steps add literal
//   expectations. Works with or without MYRISCV_MEM_CLEAR_EN defined.
module tb_myriscv_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] FILL  = 32'h0000_0013;
`ifdef MYRISCV_MEM_CLEAR_EN
  localparam bit          CLEAR_EN = 1'b1;
`else
  localparam bit          CLEAR_EN = 1'b0;
`endif
  localparam int unsigned READY_EDGE = CLEAR_EN ? DEPTH : 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  myriscv_mem_responder_if bus ();

  myriscv_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .FILL_WORD   (FILL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_ready = 1'b0;
  bit          m_fault = 1'b0;
  int unsigned m_count = 0;
  int unsigned m_edges = 0;

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

  function automatic bit legal_store(input logic [3:0] en, input logic [31:0] a);
    if ($countones(en) == 1) return 1'b1;
    if (en == 4'b0011 || en == 4'b1100) return (a % 2) == 0;
    if (en == 4'b1111) return (a % 4) == 0;
    return 1'b0;
  endfunction

  always @(negedge reset_n) begin
    m_ready = 1'b0;
    m_fault = 1'b0;
    m_count = 0;
    m_edges = 0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (!m_ready) begin
        m_edges++;
        if (m_edges == READY_EDGE) begin
          m_ready = 1'b1;
          if (CLEAR_EN) for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = FILL;
            m_known[i] = 1'b1;
          end
        end
      end else begin
        bit bad;
        bad = (bus.pc % 4 != 0) || (bus.pc >= DEPTH * 4) ||
              (bus.wr_en != 0 && (!legal_store(bus.wr_en, bus.addr) || bus.addr >= DEPTH * 4));
        if (bad) m_fault = 1'b1;
        else if (bus.wr_en != 0) begin
          int unsigned w;
          w = bus.addr / 4;
          for (int b = 0; b < 4; b++)
            if (bus.wr_en[b]) m_mem[w][8*b +: 8] = bus.wr_data[8*b +: 8];
          if (bus.wr_en == 4'b1111) m_known[w] = 1'b1;
          if (m_count < 65535) m_count++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("ready", {31'd0, bus.ready}, {31'd0, m_ready});
    check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
    check("wr_count", {16'd0, bus.wr_count}, m_count);
    if (!m_ready) begin
      check("instr_idle", bus.instr, FILL);
      check("rd_idle", bus.rd_data, 32'd0);
    end else begin
      if (bus.pc >= DEPTH * 4) check("instr_oor", bus.instr, 32'd0);
      else if (m_known[bus.pc / 4]) check("instr", bus.instr, m_mem[bus.pc / 4]);
      if (bus.addr >= DEPTH * 4) check("rd_oor", bus.rd_data, 32'd0);
      else if (m_known[bus.addr / 4]) check("rd_data", bus.rd_data, m_mem[bus.addr / 4]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] p, input logic [31:0] a,
                       input logic [3:0] en, input logic [31:0] d);
    @(posedge clk);
    #2;
    bus.pc      = p;
    bus.addr    = a;
    bus.wr_en   = en;
    bus.wr_data = d;
  endtask

  task automatic wait_ready(input string name);
    int unsigned e;
    e = 0;
    while (e < 4 * DEPTH) begin
      @(posedge clk);
      #1;
      e++;
      if (bus.ready) break;
    end
    check(name, e, READY_EDGE);
  endtask

  int unsigned base;
  int unsigned n_pre;

  initial begin
    bus.pc = '0; bus.addr = '0; bus.wr_en = '0; bus.wr_data = '0;
    #1 reset_n = 1'b0;
    @(posedge clk); #2;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_count", {16'd0, bus.wr_count}, 32'd0);
    check("rst_instr", bus.instr, 32'h0000_0013);
    check("rst_rd", bus.rd_data, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    wait_ready("ready_edge");

    // Without the sweep, memory starts unknown: fill it through the bus first.
    if (!CLEAR_EN) for (int i = 0; i < DEPTH; i++) drive(0, 4 * i, 4'b1111, FILL);
    base = CLEAR_EN ? 0 : DEPTH;

    for (int i = 0; i < DEPTH; i++) begin
      drive(4 * i, 4 * i, 4'b0000, 0);
      #1;
      check("word_fill_rd", bus.rd_data, 32'h0000_0013);
      check("word_fill_instr", bus.instr, 32'h0000_0013);
    end

    // Word store then byte store into the same word.
    drive(0, 32'h8, 4'b1111, 32'hDEAD_BEEF);
    drive(0, 32'h9, 4'b0010, 32'h0000_5500);
    drive(0, 32'h8, 4'b0000, 0);
    #1;
    check("merged_word", bus.rd_data, 32'hDEAD_55EF);
    check("count_two", {16'd0, bus.wr_count}, base + 2);

    // Misaligned halfword store.
    drive(0, 32'h3, 4'b1100, 32'hAAAA_0000);
    drive(0, 32'h0, 4'b0000, 0);
    #1;
    check("misalign_fault", {31'd0, bus.fault}, 32'd1);
    check("misalign_word0", bus.rd_data, 32'h0000_0013);
    check("misalign_count", {16'd0, bus.wr_count}, base + 2);
    for (int i = 0; i < 10; i++) drive(0, 0, 4'b0000, 0);
    #1;
    check("fault_sticky", {31'd0, bus.fault}, 32'd1);

    // Reset partway through the sweep, then a full restart.
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    check("abort_fault", {31'd0, bus.fault}, 32'd0);
    check("abort_count", {16'd0, bus.wr_count}, 32'd0);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #2;
    reset_n = 1'b1;
    wait_ready("restart_edge");

    // Out-of-range fetch with a legal store on the same edge: store dropped.
    drive(32'h40, 32'h0, 4'b1111, 32'h1234_5678);
    #1;
    check("oor_instr", bus.instr, 32'd0);
    drive(0, 32'h0, 4'b0000, 0);
    #1;
    check("oor_fault", {31'd0, bus.fault}, 32'd1);
    check("oor_word0", bus.rd_data, 32'h0000_0013);
    check("oor_count", {16'd0, bus.wr_count}, 32'd0);

    // Saturation: preload to 0xFFFE, then three legal stores.
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    wait_ready("sat_ready_edge");
    n_pre = 32'hFFFE - m_count;
    for (int unsigned i = 0; i < n_pre; i++) drive(0, 32'h3C, 4'b1111, i);
    drive(0, 0, 4'b0000, 0);
    #1;
    check("preload_count", {16'd0, bus.wr_count}, 32'h0000_FFFE);
    drive(0, 32'h4, 4'b1111, 32'h1111_1111);
    drive(0, 32'h8, 4'b1100, 32'h2222_0000);
    drive(0, 32'hE, 4'b0100, 32'h0033_0000);
    drive(0, 32'h4, 4'b0000, 0);
    #1;
    check("sat_count", {16'd0, bus.wr_count}, 32'h0000_FFFF);
    check("sat_word1", bus.rd_data, 32'h1111_1111);
    drive(0, 32'h8, 4'b0000, 0);
    #1;
    check("sat_word2", bus.rd_data, CLEAR_EN ? 32'h2222_0013 : 32'h2222_55EF);
    drive(0, 32'hC, 4'b0000, 0);
    #1;
    check("sat_word3", bus.rd_data, 32'h0033_0013);
    drive(0, 32'h10, 4'b1111, 32'h4444_4444);
    drive(0, 32'h10, 4'b0000, 0);
    #1;
    check("sat_hold", {16'd0, bus.wr_count}, 32'h0000_FFFF);
    check("sat_word4", bus.rd_data, 32'h4444_4444);

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
